zigzag_pingpong_buffer: RTL and testbench

- Parametrised successor of the single-block zigzag buffer. Collects 8 rows of quantised coefficients into one of two 64-entry banks, then streams the completed block in JPEG zigzag order or raster order.
- Sits between the quantiser (row producer) and the run-length/entropy stage.
- Ping-pong banking lets block N+1 be written while block N is read.
- Both sides use valid/ready handshakes. The output width (coefficients per beat) is configurable.

---
 rtl/jpeg_zigzag_pkg.sv | 24 ++
 rtl/zigzag_bank.sv | 44 ++++
 rtl/zigzag_pingpong_buffer.sv | 163 ++++++++++++++++
 tb/tb_zigzag_pingpong_buffer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_zigzag_pkg.sv
// Shared block geometry, the JPEG zigzag-to-raster table and the lane-count
// legality check used by the zigzag ping-pong buffer.
package jpeg_zigzag_pkg;

    localparam int BLK_DIM  = 8;
    localparam int BLK_SIZE = 64;

    // Entry k is the raster index (row*8+col) of the k-th coefficient in zigzag order.
    localparam logic [5:0] ZIGZAG_IDX [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic bit is_legal_lanes(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8);
    endfunction

endpackage

// File: rtl/zigzag_bank.sv
// One 64-coefficient block store: row-wide write port, OUT_LANES combinational
// read ports addressed by raster index, and the block's zigzag/raster mode bit.
module zigzag_bank
    import jpeg_zigzag_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int OUT_LANES  = 1
) (
    input  logic                              clock,
    input  logic                              wr_en_i,
    input  logic [2:0]                        wr_row_i,
    input  logic [BLK_DIM*DATA_WIDTH-1:0]     wr_data_i,
    input  logic                              mode_we_i,
    input  logic                              mode_i,
    output logic                              mode_o,
    input  logic [OUT_LANES*6-1:0]            rd_addr_i,
    output logic [OUT_LANES*DATA_WIDTH-1:0]   rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [BLK_SIZE];
    logic                  modeBit_q;

    // Storage is deliberately left out of reset; a block is always fully rewritten before it is read.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            for (int c = 0; c < BLK_DIM; c++) begin
                mem_q[{wr_row_i, 3'(c)}] <= wr_data_i[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (mode_we_i) begin
            modeBit_q <= mode_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int j = 0; j < OUT_LANES; j++) begin
            rd_data_o[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr_i[j*6 +: 6]];
        end
    end

    assign mode_o = modeBit_q;

endmodule

// File: rtl/zigzag_pingpong_buffer.sv
// Two-bank row collector that streams each completed 8x8 block in zigzag or
// raster order, OUT_LANES coefficients per beat, with valid/ready on both sides.
module zigzag_pingpong_buffer
    import jpeg_zigzag_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int OUT_LANES  = 1
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BLK_DIM*DATA_WIDTH-1:0]     in_row,
    input  logic                              in_zigzag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUT_LANES*DATA_WIDTH-1:0]   out_data,
    output logic                              out_first,
    output logic                              out_last,
    output logic [1:0]                        bank_full
);

    localparam int BEATS = BLK_SIZE / OUT_LANES;
    localparam int BW    = $clog2(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (!is_legal_lanes(OUT_LANES)) begin : g_illegal_lanes
        $error("zigzag_pingpong_buffer: OUT_LANES must be 1, 2, 4 or 8");
    end

    logic                            wrBank_q, wrBank_d;
    logic [2:0]                      wrRow_q, wrRow_d;
    logic                            rdBank_q, rdBank_d;
    logic                            rdDone_q, rdDone_d;
    logic [BW-1:0]                   beat_q, beat_d;
    logic [1:0]                      bankFull_q, bankFull_d;
    logic                            outValid_q, outValid_d;
    logic [OUT_LANES*DATA_WIDTH-1:0] outData_q, outData_d;
    logic                            outFirst_q, outFirst_d;
    logic                            outLast_q, outLast_d;

    logic                            wrFire, wrLast;
    logic [1:0]                      fullNow;
    logic                            accept, lastAccept;
    logic                            srcBank, srcPending, load;
    logic                            rdMode;
    logic [5:0]                      seqBase;
    logic [OUT_LANES*6-1:0]          rdAddr;
    logic [OUT_LANES*DATA_WIDTH-1:0] bankData [2];
    logic [1:0]                      bankMode;

    assign in_ready = !bankFull_q[wrBank_q];
    assign wrFire   = in_valid && in_ready;
    assign wrLast   = wrFire && (wrRow_q == 3'd7);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        zigzag_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .OUT_LANES  (OUT_LANES)
        ) u_bank (
            .clock      (clock),
            .wr_en_i    (wrFire && (wrBank_q == 1'(b))),
            .wr_row_i   (wrRow_q),
            .wr_data_i  (in_row),
            .mode_we_i  (wrFire && (wrBank_q == 1'(b)) && (wrRow_q == 3'd0)),
            .mode_i     (in_zigzag),
            .mode_o     (bankMode[b]),
            .rd_addr_i  (rdAddr),
            .rd_data_o  (bankData[b])
        );
    end

    // Beat 0 never touches row 7 in either order, so a bank may start reading in the
    // very cycle its row 7 is written; this gives the one-cycle first-beat latency.
    always_comb begin
        fullNow    = bankFull_q | (wrLast ? (2'b01 << wrBank_q) : 2'b00);
        accept     = outValid_q && out_ready;
        lastAccept = accept && outLast_q;
        srcBank    = lastAccept ? !rdBank_q : rdBank_q;
        srcPending = fullNow[srcBank] && (lastAccept || !rdDone_q);
        load       = (!outValid_q || out_ready) && srcPending;
        rdMode     = bankMode[srcBank];
        seqBase    = 6'(beat_q) * 6'(OUT_LANES);
        rdAddr     = '0;
        for (int j = 0; j < OUT_LANES; j++) begin
            rdAddr[j*6 +: 6] = rdMode ? ZIGZAG_IDX[seqBase + 6'(j)] : (seqBase + 6'(j));
        end
    end

    always_comb begin
        wrBank_d   = wrBank_q;
        wrRow_d    = wrRow_q;
        rdBank_d   = srcBank;
        rdDone_d   = rdDone_q && !lastAccept;
        beat_d     = beat_q;
        bankFull_d = bankFull_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outFirst_d = outFirst_q;
        outLast_d  = outLast_q;

        if (wrFire) begin
            wrRow_d = wrRow_q + 3'd1;
            if (wrLast) begin
                wrBank_d             = !wrBank_q;
                bankFull_d[wrBank_q] = 1'b1;
            end
        end
        if (lastAccept) begin
            bankFull_d[rdBank_q] = 1'b0;
        end

        if (load) begin
            outValid_d = 1'b1;
            outData_d  = bankData[srcBank];
            outFirst_d = (beat_q == '0);
            outLast_d  = (beat_q == LAST_BEAT);
            if (beat_q == LAST_BEAT) begin
                beat_d   = '0;
                rdDone_d = 1'b1;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end else if (accept) begin
            outValid_d = 1'b0;
            outFirst_d = 1'b0;
            outLast_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrBank_q   <= 1'b0;
            wrRow_q    <= 3'd0;
            rdBank_q   <= 1'b0;
            rdDone_q   <= 1'b0;
            beat_q     <= '0;
            bankFull_q <= 2'b00;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outFirst_q <= 1'b0;
            outLast_q  <= 1'b0;
        end else begin
            wrBank_q   <= wrBank_d;
            wrRow_q    <= wrRow_d;
            rdBank_q   <= rdBank_d;
            rdDone_q   <= rdDone_d;
            beat_q     <= beat_d;
            bankFull_q <= bankFull_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outFirst_q <= outFirst_d;
            outLast_q  <= outLast_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_first = outFirst_q;
    assign out_last  = outLast_q;
    assign bank_full = bankFull_q;

endmodule

// File: tb/tb_zigzag_pingpong_buffer.sv
// Scoreboard bench: one single-lane and one eight-lane buffer, expected beats
// queued when a block completes and compared as the consumer accepts them.
module tb_zigzag_pingpong_buffer;

    localparam int DW = 10;

    logic              clock = 1'b0;
    logic              resetN;
    logic              inValid, inReady, inZigzag, outValid, outReady, outFirst, outLast;
    logic [8*DW-1:0]   inRow;
    logic [DW-1:0]     outData;
    logic [1:0]        bankFull;
    logic              inValid8, inReady8, inZigzag8, outValid8, outReady8, outFirst8, outLast8;
    logic [8*DW-1:0]   inRow8, outData8;
    logic [1:0]        bankFull8;

    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                rowsSent = 0;
    int                row7Cyc = 0;
    int                firstValidCyc = -1;
    int                zzTab [64];
    logic [DW-1:0]     expQ [$];
    logic [8*DW-1:0]   expQ8 [$];

    zigzag_pingpong_buffer #(.DATA_WIDTH(DW), .OUT_LANES(1)) dut1 (
        .clock(clock), .reset_n(resetN), .in_valid(inValid), .in_ready(inReady),
        .in_row(inRow), .in_zigzag(inZigzag), .out_valid(outValid), .out_ready(outReady),
        .out_data(outData), .out_first(outFirst), .out_last(outLast), .bank_full(bankFull)
    );

    zigzag_pingpong_buffer #(.DATA_WIDTH(DW), .OUT_LANES(8)) dut8 (
        .clock(clock), .reset_n(resetN), .in_valid(inValid8), .in_ready(inReady8),
        .in_row(inRow8), .in_zigzag(inZigzag8), .out_valid(outValid8), .out_ready(outReady8),
        .out_data(outData8), .out_first(outFirst8), .out_last(outLast8), .bank_full(bankFull8)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] elemVal(input int tag, input int idx);
        return DW'((tag * 64 + idx) % 1024);
    endfunction

    function automatic logic [8*DW-1:0] rowVal(input int tag, input int r);
        logic [8*DW-1:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) v[c*DW +: DW] = elemVal(tag, r * 8 + c);
        return v;
    endfunction

    // Zigzag order generated by walking anti-diagonals, independent of the RTL table.
    task automatic buildZigzag();
        int n, lo, hi;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zzTab[n] = r * 8 + (s - r); n++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zzTab[n] = r * 8 + (s - r); n++; end
            end
        end
    endtask

    task automatic sendRows1(input int tag, input bit zz, input int nRows, input bit push);
        int waited;
        for (int r = 0; r < nRows; r++) begin
            waited = 0;
            @(negedge clock);
            inValid = 1'b1; inRow = rowVal(tag, r); inZigzag = zz;
            while (!inReady && waited < 2000) begin @(negedge clock); waited++; end
            if (!inReady) begin
                checks++; errors++;
                $display("[TB] FAIL send_timeout: row %0d of tag %0d, in_ready %b required 1", r, tag, inReady);
                inValid = 1'b0;
                return;
            end
            if (r == 7) row7Cyc = cyc;
            @(posedge clock);
            rowsSent++;
        end
        #1 inValid = 1'b0;
        if (push && nRows == 8)
            for (int k = 0; k < 64; k++) expQ.push_back(elemVal(tag, zz ? zzTab[k] : k));
    endtask

    task automatic sendRows8(input int tag, input bit zz);
        int waited;
        logic [8*DW-1:0] beat;
        for (int r = 0; r < 8; r++) begin
            waited = 0;
            @(negedge clock);
            inValid8 = 1'b1; inRow8 = rowVal(tag, r); inZigzag8 = zz;
            while (!inReady8 && waited < 2000) begin @(negedge clock); waited++; end
            if (!inReady8) begin
                checks++; errors++;
                $display("[TB] FAIL send8_timeout: row %0d, in_ready %b required 1", r, inReady8);
                inValid8 = 1'b0;
                return;
            end
            @(posedge clock);
        end
        #1 inValid8 = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < 8; j++) beat[j*DW +: DW] = elemVal(tag, zz ? zzTab[b*8+j] : b*8+j);
            expQ8.push_back(beat);
        end
    endtask

    task automatic receiveBeats1(input int n, input int readyPct);
        int got, waited, pos;
        bit held;
        logic [DW-1:0] hData, exp;
        logic hF, hL;
        got = 0; waited = 0; pos = 0; held = 0; hData = '0; hF = 0; hL = 0;
        while (got < n && waited < n * 20 + 2000) begin
            @(negedge clock);
            if (held) begin
                checks++;
                if (outValid !== 1'b1 || outData !== hData || outFirst !== hF || outLast !== hL) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: valid %b data %0d first %b last %b, required 1 %0d %b %b",
                             outValid, outData, outFirst, outLast, hData, hF, hL);
                end
            end
            if (firstValidCyc < 0 && outValid === 1'b1) firstValidCyc = cyc;
            outReady = ($urandom_range(99) < readyPct);
            if (outValid === 1'b1 && outReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL extra_beat: data %0d arrived, required no beat", outData);
                end else begin
                    exp = expQ.pop_front();
                    if (outData !== exp) begin
                        errors++;
                        $display("[TB] FAIL beat_data: beat %0d got %0d required %0d", got, outData, exp);
                    end
                    checks++;
                    if (outFirst !== (pos == 0)) begin
                        errors++;
                        $display("[TB] FAIL beat_first: beat %0d got %b required %b", got, outFirst, pos == 0);
                    end
                    checks++;
                    if (outLast !== (pos == 63)) begin
                        errors++;
                        $display("[TB] FAIL beat_last: beat %0d got %b required %b", got, outLast, pos == 63);
                    end
                end
                got++; pos = (pos + 1) % 64; held = 0;
            end else begin
                held = (outValid === 1'b1);
                hData = outData; hF = outFirst; hL = outLast;
            end
            waited++;
        end
        if (got < n) begin
            checks++; errors++;
            $display("[TB] FAIL receive_timeout: got %0d beats required %0d", got, n);
        end
        @(posedge clock);
        #1 outReady = 1'b0;
    endtask

    task automatic receiveBeats8(input int n);
        int got, waited;
        int beat0Exp [8] = '{0, 1, 8, 16, 9, 2, 3, 10};
        logic [8*DW-1:0] exp;
        got = 0; waited = 0;
        while (got < n && waited < 2000) begin
            @(negedge clock);
            outReady8 = 1'b1;
            if (outValid8 === 1'b1) begin
                exp = (expQ8.size() > 0) ? expQ8.pop_front() : '0;
                checks++;
                if (outData8 !== exp) begin
                    errors++;
                    $display("[TB] FAIL lanes8_data: beat %0d got %h required %h", got, outData8, exp);
                end
                if (got == 0) begin
                    for (int j = 0; j < 8; j++) begin
                        checks++;
                        if (outData8[j*DW +: DW] !== DW'(beat0Exp[j])) begin
                            errors++;
                            $display("[TB] FAIL lanes8_beat0: lane %0d got %0d required %0d", j, outData8[j*DW +: DW], beat0Exp[j]);
                        end
                    end
                end
                checks++;
                if (outFirst8 !== (got == 0) || outLast8 !== (got == n - 1)) begin
                    errors++;
                    $display("[TB] FAIL lanes8_flags: beat %0d first %b last %b required %b %b",
                             got, outFirst8, outLast8, got == 0, got == n - 1);
                end
                got++;
            end
            waited++;
        end
        if (got < n) begin
            checks++; errors++;
            $display("[TB] FAIL lanes8_timeout: got %0d beats required %0d", got, n);
        end
        @(posedge clock);
        #1 outReady8 = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checks++;
        if (outValid !== 1'b0 || outData !== '0 || outFirst !== 1'b0 || outLast !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_outputs: valid %b data %0d first %b last %b required 0 0 0 0",
                     tag, outValid, outData, outFirst, outLast);
        end
        checks++;
        if (bankFull !== 2'b00) begin
            errors++;
            $display("[TB] FAIL %s_bank_full: got %b required 00", tag, bankFull);
        end
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_in_ready: got %b required 1", tag, inReady);
        end
    endtask

    task automatic checkIdle(input string tag);
        repeat (3) @(negedge clock);
        checks++;
        if (outValid !== 1'b0 || bankFull !== 2'b00) begin
            errors++;
            $display("[TB] FAIL %s_idle: valid %b bank_full %b required 0 00", tag, outValid, bankFull);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        inValid = 0; inRow = '0; inZigzag = 0; outReady = 0;
        inValid8 = 0; inRow8 = '0; inZigzag8 = 0; outReady8 = 0;
        #12;
        checkResetState("reset");
        checks++;
        if (outValid8 !== 1'b0 || outData8 !== '0 || bankFull8 !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_lanes8: valid %b data %h bank_full %b required 0 0 00", outValid8, outData8, bankFull8);
        end
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        checkResetState("post_reset");
    endtask

    task automatic test_zigzag_single();
        firstValidCyc = -1;
        fork
            sendRows1(0, 1'b1, 8, 1'b1);
            receiveBeats1(64, 100);
        join
        checks++;
        if (firstValidCyc !== row7Cyc + 1) begin
            errors++;
            $display("[TB] FAIL first_latency: out_valid at cycle %0d required %0d", firstValidCyc, row7Cyc + 1);
        end
        checkIdle("zigzag");
    endtask

    task automatic test_raster_single();
        fork
            sendRows1(0, 1'b0, 8, 1'b1);
            receiveBeats1(64, 100);
        join
        checkIdle("raster");
    endtask

    task automatic test_lanes8();
        fork
            sendRows8(0, 1'b1);
            receiveBeats8(8);
        join
        repeat (3) @(negedge clock);
        checks++;
        if (outValid8 !== 1'b0 || bankFull8 !== 2'b00) begin
            errors++;
            $display("[TB] FAIL lanes8_idle: valid %b bank_full %b required 0 00", outValid8, bankFull8);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        rowsSent = 0;
        outReady = 1'b0;
        fork
            begin
                sendRows1(1, 1'b1, 8, 1'b1);
                sendRows1(2, 1'b0, 8, 1'b1);
                sendRows1(3, 1'b1, 8, 1'b1);
            end
            begin
                w = 0;
                while (rowsSent < 16 && w < 1000) begin @(negedge clock); w++; end
                repeat (20) @(negedge clock);
                checks++;
                if (rowsSent !== 16) begin
                    errors++;
                    $display("[TB] FAIL stall_rows: %0d rows accepted required 16", rowsSent);
                end
                checks++;
                if (inReady !== 1'b0 || bankFull !== 2'b11) begin
                    errors++;
                    $display("[TB] FAIL both_full: in_ready %b bank_full %b required 0 11", inReady, bankFull);
                end
                checks++;
                if (outValid !== 1'b1 || outFirst !== 1'b1 || expQ.size() == 0 || outData !== expQ[0]) begin
                    errors++;
                    $display("[TB] FAIL stalled_head: valid %b first %b data %0d required 1 1 %0d",
                             outValid, outFirst, outData, elemVal(1, 0));
                end
                receiveBeats1(192, 100);
            end
        join
        checkIdle("back_to_back");
    endtask

    task automatic test_random_stall();
        fork
            begin
                sendRows1(4, 1'b1, 8, 1'b1);
                sendRows1(5, 1'b0, 8, 1'b1);
                sendRows1(6, 1'b1, 8, 1'b1);
            end
            receiveBeats1(192, 50);
        join
        checkIdle("random_stall");
    endtask

    task automatic test_reset_mid();
        outReady = 1'b0;
        sendRows1(7, 1'b1, 8, 1'b0);
        sendRows1(8, 1'b1, 5, 1'b0);
        @(negedge clock);
        #2 resetN = 1'b0;
        #1 checkResetState("reset_mid_write");
        @(negedge clock);
        resetN = 1'b1;
        sendRows1(9, 1'b0, 8, 1'b0);
        @(negedge clock);
        outReady = 1'b1;
        repeat (10) @(negedge clock);
        #2 resetN = 1'b0;
        #1 checkResetState("reset_mid_read");
        outReady = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        sendRows1(10, 1'b1, 8, 1'b1);
        @(negedge clock);
        checks++;
        if (bankFull !== 2'b01) begin
            errors++;
            $display("[TB] FAIL clean_bank0: bank_full %b required 01", bankFull);
        end
        receiveBeats1(64, 100);
        checkIdle("reset_mid");
    endtask

    initial begin
        buildZigzag();
        test_reset();
        test_zigzag_single();
        test_raster_single();
        test_lanes8();
        test_back_to_back();
        test_random_stall();
        test_reset_mid();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover_expected: %0d beats never arrived, required 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
